// File: rtl/fifo_vr_pkt.sv
// -----------------------------------------------------------------------------
// fifo_vr_pkt
//
// Valid-ready FIFO for accelerator datapaths with arbitrary depth, fill-level /
// packet-count / almost-full / almost-empty status, and an optional
// store-and-forward packet mode with a cut-through fallback for packets that
// are larger than the FIFO itself.
//
// Ready and valid depend only on registered state plus the control inputs
// (nrst, sync_rst, en); data_out_ready never reaches data_in_ready.
//
// Parameters
//   DEPTH       number of entries (>= 2, need not be a power of two)
//   DATA_W      payload width
//   PKT_MODE    0 = stream, 1 = store-and-forward on data_in_last
//   AFULL_LVL   almost_full when level >= AFULL_LVL
//   AEMPTY_LVL  almost_empty when level <= AEMPTY_LVL
//   CNT_W       width of level / pkt_count
//
// Ports
//   clk            rising-edge clock
//   nrst           synchronous active-low reset
//   en             enable; low freezes all state and drops ready/valid
//   sync_rst       synchronous local clear (same effect as nrst low)
//   data_in        write payload
//   data_in_last   write beat ends its packet
//   data_in_valid  write request
//   data_in_ready  FIFO can accept a beat
//   data_out       head payload
//   data_out_last  head beat ends its packet
//   data_out_valid head beat is available
//   data_out_ready consumer takes the head beat
//   level          stored beats, 0..DEPTH
//   pkt_count      complete packets stored
//   almost_full    level >= AFULL_LVL
//   almost_empty   level <= AEMPTY_LVL
// -----------------------------------------------------------------------------
module fifo_vr_pkt #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter bit PKT_MODE   = 1'b0,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              sync_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_last,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_last,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  // Storage: {payload, last}. Not reset; contents are only meaningful
  // between rd_ptr and wr_ptr.
  logic [DATA_W:0]    mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   pkt_q, pkt_d;
  logic               ct_q, ct_d;

  logic               clr;
  logic               run;
  logic               wr_shake;
  logic               rd_shake;
  logic               wr_last;
  logic               rd_last;
  logic               head_last;
  logic               have_pkt;

  assign clr = !nrst || sync_rst;
  assign run = !clr && en;

  // Head entry is read straight from the array; only valid when
  // data_out_valid is high.
  assign data_out      = mem_q[rd_ptr_q][DATA_W:1];
  assign head_last     = mem_q[rd_ptr_q][0];
  assign data_out_last = head_last;

  // In packet mode the head may only leave once a complete packet is held,
  // or once cut-through has been forced because the FIFO filled with a
  // single unterminated packet.
  assign have_pkt = PKT_MODE ? ((pkt_q != '0) || ct_q) : 1'b1;

  assign data_in_ready  = run && (level_q < DEPTH_C);
  assign data_out_valid = run && have_pkt && (level_q != '0);

  assign wr_shake = data_in_valid && data_in_ready;
  assign rd_shake = data_out_valid && data_out_ready;
  assign wr_last  = wr_shake && data_in_last;
  assign rd_last  = rd_shake && head_last;

  assign level        = level_q;
  assign pkt_count    = pkt_q;
  assign almost_full  = (level_q >= AFULL_C);
  assign almost_empty = (level_q <= AEMPTY_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    ct_d     = ct_q;

    // Explicit wrap so that non-power-of-two depths work.
    if (wr_shake) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_shake) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({wr_shake, rd_shake})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case ({wr_last, rd_last})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase

    // A full FIFO with no complete packet can never make progress in
    // store-and-forward mode, so switch to cut-through until the last
    // beat of the head packet has been read. Frozen while en is low.
    if (PKT_MODE && run) begin
      if (rd_last) begin
        ct_d = 1'b0;
      end else if ((level_q == DEPTH_C) && (pkt_q == '0)) begin
        ct_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      ct_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      ct_q     <= ct_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_shake) begin
      mem_q[wr_ptr_q] <= {data_in, data_in_last};
    end
  end

endmodule

// File: tb/tb_fifo_vr_pkt.sv
// Bench for fifo_vr_pkt: one stream-mode instance (DEPTH=5) and one
// packet-mode instance (DEPTH=4). A queue-based reference model predicts
// every output from the FIFO rules; directed tasks also use literal values.
module tb_fifo_vr_pkt;

  localparam int DW = 16;
  typedef logic [DW:0] beat_t;

  logic clk;
  logic [1:0]         nrst_v, srst_v, en_v, vin, lin, ordy;
  logic [1:0][DW-1:0] din;
  logic [1:0]         rdy, vld, olast, af, ae;
  logic [1:0][DW-1:0] dout;
  logic [1:0][2:0]    lvl, pkt;

  int cmp_n  = 0;
  int fail_n = 0;

  // Reference model state
  beat_t      mq [2][$];
  bit         mct [2];
  logic [1:0] e_rdy, e_vld, e_af, e_ae;
  logic [2:0] e_lvl [2];
  logic [2:0] e_pkt [2];
  beat_t      e_head [2];

  fifo_vr_pkt #(.DEPTH(5), .DATA_W(DW), .PKT_MODE(1'b0)) u_str (
    .clk(clk), .nrst(nrst_v[0]), .en(en_v[0]), .sync_rst(srst_v[0]),
    .data_in(din[0]), .data_in_last(lin[0]), .data_in_valid(vin[0]),
    .data_in_ready(rdy[0]), .data_out(dout[0]), .data_out_last(olast[0]),
    .data_out_valid(vld[0]), .data_out_ready(ordy[0]), .level(lvl[0]),
    .pkt_count(pkt[0]), .almost_full(af[0]), .almost_empty(ae[0])
  );

  fifo_vr_pkt #(.DEPTH(4), .DATA_W(DW), .PKT_MODE(1'b1)) u_pkt (
    .clk(clk), .nrst(nrst_v[1]), .en(en_v[1]), .sync_rst(srst_v[1]),
    .data_in(din[1]), .data_in_last(lin[1]), .data_in_valid(vin[1]),
    .data_in_ready(rdy[1]), .data_out(dout[1]), .data_out_last(olast[1]),
    .data_out_valid(vld[1]), .data_out_ready(ordy[1]), .level(lvl[1]),
    .pkt_count(pkt[1]), .almost_full(af[1]), .almost_empty(ae[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(int u);
    return (u == 0) ? 5 : 4;
  endfunction

  // Predict combinational outputs from model state and current inputs.
  task automatic eval();
    #1;
    for (int u = 0; u < 2; u++) begin
      int n;
      int pk;
      bit run;
      n  = mq[u].size();
      pk = 0;
      for (int i = 0; i < n; i++) if (mq[u][i][0]) pk++;
      run = nrst_v[u] && !srst_v[u] && en_v[u];
      e_rdy[u] = run && (n < dep(u));
      e_vld[u] = run && (n > 0) && ((u == 0) || (pk > 0) || mct[u]);
      e_lvl[u] = 3'(n);
      e_pkt[u] = 3'(pk);
      e_af[u]  = (n >= dep(u) - 1);
      e_ae[u]  = (n <= 1);
      e_head[u] = (n > 0) ? mq[u][0] : '0;
    end
  endtask

  // Advance the model across one rising edge, then return to the falling edge.
  task automatic clk_step();
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      bit    setc;
      beat_t b;
      if (!nrst_v[u] || srst_v[u]) begin
        mq[u].delete();
        mct[u] = 1'b0;
      end else if (en_v[u]) begin
        setc = (u == 1) && (int'(e_lvl[u]) == dep(u)) && (e_pkt[u] == 3'd0);
        if (e_vld[u] && ordy[u]) begin
          b = mq[u].pop_front();
          if (b[0]) mct[u] = 1'b0;
          else if (setc) mct[u] = 1'b1;
        end else if (setc) begin
          mct[u] = 1'b1;
        end
        if (vin[u] && e_rdy[u]) mq[u].push_back({din[u], lin[u]});
      end
    end
    @(negedge clk);
  endtask

  task automatic clear();
    nrst_v = 2'b11; en_v = 2'b11; srst_v = 2'b11;
    vin = 2'b00; lin = 2'b00; ordy = 2'b00;
    eval();
    clk_step();
    srst_v = 2'b00;
  endtask

  task automatic test_reset();
    nrst_v = 2'b00; vin = 2'b11;
    eval();
    for (int u = 0; u < 2; u++) begin
      cmp_n++; if (rdy[u] !== 1'b0) begin fail_n++; $display("FAIL reset_ready_in_rst[%0d]: got %b want 0", u, rdy[u]); end
      cmp_n++; if (vld[u] !== 1'b0) begin fail_n++; $display("FAIL reset_valid_in_rst[%0d]: got %b want 0", u, vld[u]); end
    end
    clk_step();
    eval();
    for (int u = 0; u < 2; u++) begin
      cmp_n++; if (lvl[u] !== 3'd0) begin fail_n++; $display("FAIL reset_level[%0d]: got %0d want 0", u, lvl[u]); end
      cmp_n++; if (pkt[u] !== 3'd0) begin fail_n++; $display("FAIL reset_pkt[%0d]: got %0d want 0", u, pkt[u]); end
      cmp_n++; if (ae[u] !== 1'b1) begin fail_n++; $display("FAIL reset_aempty[%0d]: got %b want 1", u, ae[u]); end
      cmp_n++; if (af[u] !== 1'b0) begin fail_n++; $display("FAIL reset_afull[%0d]: got %b want 0", u, af[u]); end
    end
    nrst_v = 2'b11; vin = 2'b00;
    eval();
    for (int u = 0; u < 2; u++) begin
      cmp_n++; if (rdy[u] !== 1'b1) begin fail_n++; $display("FAIL reset_ready_release[%0d]: got %b want 1", u, rdy[u]); end
      cmp_n++; if (vld[u] !== 1'b0) begin fail_n++; $display("FAIL reset_valid_release[%0d]: got %b want 0", u, vld[u]); end
    end
    clk_step();
  endtask

  task automatic test_stream_fill();
    int k;
    clear();
    k = 0;
    for (int c = 0; c < 7; c++) begin
      vin[0] = 1'b1; lin[0] = 1'b0; din[0] = 16'(32'h10 + k);
      eval();
      cmp_n++; if (rdy[0] !== e_rdy[0]) begin fail_n++; $display("FAIL fill_ready c%0d: got %b want %b", c, rdy[0], e_rdy[0]); end
      if (e_rdy[0]) k++;
      clk_step();
    end
    for (int i = 0; i < 5; i++) begin
      vin[0] = (i == 0); din[0] = 16'h15; ordy[0] = 1'b1;
      eval();
      if (i == 0) begin
        cmp_n++; if (lvl[0] !== 3'd5) begin fail_n++; $display("FAIL fill_level: got %0d want 5", lvl[0]); end
        cmp_n++; if (af[0] !== 1'b1) begin fail_n++; $display("FAIL fill_afull: got %b want 1", af[0]); end
        cmp_n++; if (rdy[0] !== 1'b0) begin fail_n++; $display("FAIL full_read_ready: got %b want 0", rdy[0]); end
      end
      if (i == 1) begin
        cmp_n++; if (rdy[0] !== 1'b1) begin fail_n++; $display("FAIL ready_after_read: got %b want 1", rdy[0]); end
      end
      cmp_n++; if (vld[0] !== 1'b1) begin fail_n++; $display("FAIL drain_valid %0d: got %b want 1", i, vld[0]); end
      cmp_n++; if (dout[0] !== 16'(32'h10 + i)) begin fail_n++; $display("FAIL drain_data %0d: got %h want %h", i, dout[0], 32'h10 + i); end
      clk_step();
    end
    vin[0] = 1'b0;
    eval();
    cmp_n++; if (vld[0] !== 1'b0) begin fail_n++; $display("FAIL drain_empty_valid: got %b want 0", vld[0]); end
    cmp_n++; if (lvl[0] !== 3'd0) begin fail_n++; $display("FAIL drain_empty_level: got %0d want 0", lvl[0]); end
    ordy[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear();
    vin[0] = 1'b1; ordy[0] = 1'b1; lin[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      din[0] = 16'(32'h100 + c);
      eval();
      cmp_n++; if (vld[0] !== (c != 0)) begin fail_n++; $display("FAIL b2b_valid c%0d: got %b want %b", c, vld[0], c != 0); end
      cmp_n++; if (lvl[0] !== ((c == 0) ? 3'd0 : 3'd1)) begin fail_n++; $display("FAIL b2b_level c%0d: got %0d", c, lvl[0]); end
      if (c != 0) begin
        cmp_n++; if (dout[0] !== 16'(32'h100 + c - 1)) begin fail_n++; $display("FAIL b2b_data c%0d: got %h want %h", c, dout[0], 32'h100 + c - 1); end
      end
      clk_step();
    end
    vin[0] = 1'b0;
    eval();
    clk_step();
    ordy[0] = 1'b0;
  endtask

  task automatic test_pkt_small();
    clear();
    ordy[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      vin[1] = 1'b1; din[1] = 16'(32'hA0 + c); lin[1] = (c == 2);
      eval();
      cmp_n++; if (vld[1] !== 1'b0) begin fail_n++; $display("FAIL pkt_early_valid c%0d: got %b want 0", c, vld[1]); end
      clk_step();
    end
    vin[1] = 1'b0; lin[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      eval();
      cmp_n++; if (vld[1] !== 1'b1) begin fail_n++; $display("FAIL pkt_valid c%0d: got %b want 1", c, vld[1]); end
      cmp_n++; if (dout[1] !== 16'(32'hA0 + c)) begin fail_n++; $display("FAIL pkt_data c%0d: got %h want %h", c, dout[1], 32'hA0 + c); end
      cmp_n++; if (olast[1] !== (c == 2)) begin fail_n++; $display("FAIL pkt_last c%0d: got %b", c, olast[1]); end
      cmp_n++; if (pkt[1] !== 3'd1) begin fail_n++; $display("FAIL pkt_count c%0d: got %0d want 1", c, pkt[1]); end
      clk_step();
    end
    eval();
    cmp_n++; if (vld[1] !== 1'b0) begin fail_n++; $display("FAIL pkt_done_valid: got %b want 0", vld[1]); end
    cmp_n++; if (pkt[1] !== 3'd0) begin fail_n++; $display("FAIL pkt_done_count: got %0d want 0", pkt[1]); end
    ordy[1] = 1'b0;
  endtask

  task automatic test_pkt_oversize();
    int k;
    int got;
    int obs;
    clear();
    ordy[1] = 1'b1; k = 0; got = 0; obs = 0;
    for (int c = 0; c < 30; c++) begin
      vin[1] = (k < 6); din[1] = 16'(32'hC0 + k); lin[1] = (k == 5);
      eval();
      cmp_n++; if (vld[1] !== e_vld[1]) begin fail_n++; $display("FAIL ovs_valid c%0d: got %b want %b", c, vld[1], e_vld[1]); end
      cmp_n++; if (rdy[1] !== e_rdy[1]) begin fail_n++; $display("FAIL ovs_ready c%0d: got %b want %b", c, rdy[1], e_rdy[1]); end
      cmp_n++; if (lvl[1] !== e_lvl[1]) begin fail_n++; $display("FAIL ovs_level c%0d: got %0d want %0d", c, lvl[1], e_lvl[1]); end
      if (vld[1] === 1'b1) obs++;
      if (e_vld[1]) begin
        cmp_n++; if (dout[1] !== 16'(32'hC0 + got)) begin fail_n++; $display("FAIL ovs_data %0d: got %h want %h", got, dout[1], 32'hC0 + got); end
        cmp_n++; if (olast[1] !== (got == 5)) begin fail_n++; $display("FAIL ovs_last %0d: got %b", got, olast[1]); end
        got++;
      end
      if (vin[1] && e_rdy[1]) k++;
      clk_step();
    end
    vin[1] = 1'b0;
    eval();
    cmp_n++; if (obs !== 6) begin fail_n++; $display("FAIL ovs_beats_out: got %0d want 6", obs); end
    cmp_n++; if (vld[1] !== 1'b0) begin fail_n++; $display("FAIL ovs_final_valid: got %b want 0", vld[1]); end
    ordy[1] = 1'b0;
  endtask

  task automatic test_enable();
    clear();
    for (int c = 0; c < 2; c++) begin
      vin[0] = 1'b1; din[0] = 16'(32'h31 + c);
      eval();
      clk_step();
    end
    en_v[0] = 1'b0; vin[0] = 1'b1; din[0] = 16'h99; ordy[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      eval();
      cmp_n++; if (rdy[0] !== 1'b0) begin fail_n++; $display("FAIL en_ready c%0d: got %b want 0", c, rdy[0]); end
      cmp_n++; if (vld[0] !== 1'b0) begin fail_n++; $display("FAIL en_valid c%0d: got %b want 0", c, vld[0]); end
      cmp_n++; if (lvl[0] !== 3'd2) begin fail_n++; $display("FAIL en_level c%0d: got %0d want 2", c, lvl[0]); end
      clk_step();
    end
    en_v[0] = 1'b1; vin[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      eval();
      cmp_n++; if (vld[0] !== 1'b1) begin fail_n++; $display("FAIL en_resume_valid c%0d: got %b want 1", c, vld[0]); end
      cmp_n++; if (dout[0] !== 16'(32'h31 + c)) begin fail_n++; $display("FAIL en_resume_data c%0d: got %h want %h", c, dout[0], 32'h31 + c); end
      clk_step();
    end
    eval();
    cmp_n++; if (vld[0] !== 1'b0) begin fail_n++; $display("FAIL en_empty_valid: got %b want 0", vld[0]); end
    ordy[0] = 1'b0;
  endtask

  task automatic test_local_clear();
    for (int r = 0; r < 2; r++) begin
      clear();
      for (int c = 0; c < 3; c++) begin
        vin[1] = 1'b1; din[1] = 16'(32'h50 + c); lin[1] = (c == 1);
        eval();
        clk_step();
      end
      eval();
      cmp_n++; if (lvl[1] !== 3'd3) begin fail_n++; $display("FAIL clr%0d_pre_level: got %0d want 3", r, lvl[1]); end
      cmp_n++; if (pkt[1] !== 3'd1) begin fail_n++; $display("FAIL clr%0d_pre_pkt: got %0d want 1", r, pkt[1]); end
      if (r == 0) srst_v[1] = 1'b1; else nrst_v[1] = 1'b0;
      din[1] = 16'hEE; lin[1] = 1'b1; ordy[1] = 1'b1;
      eval();
      cmp_n++; if (rdy[1] !== 1'b0) begin fail_n++; $display("FAIL clr%0d_ready: got %b want 0", r, rdy[1]); end
      cmp_n++; if (vld[1] !== 1'b0) begin fail_n++; $display("FAIL clr%0d_valid: got %b want 0", r, vld[1]); end
      clk_step();
      srst_v[1] = 1'b0; nrst_v[1] = 1'b1; vin[1] = 1'b0; ordy[1] = 1'b0;
      eval();
      cmp_n++; if (lvl[1] !== 3'd0) begin fail_n++; $display("FAIL clr%0d_level: got %0d want 0", r, lvl[1]); end
      cmp_n++; if (pkt[1] !== 3'd0) begin fail_n++; $display("FAIL clr%0d_pkt: got %0d want 0", r, pkt[1]); end
      cmp_n++; if (vld[1] !== 1'b0) begin fail_n++; $display("FAIL clr%0d_post_valid: got %b want 0", r, vld[1]); end
      vin[1] = 1'b1; din[1] = 16'h60; lin[1] = 1'b1;
      clk_step();
      vin[1] = 1'b0; lin[1] = 1'b0; ordy[1] = 1'b1;
      eval();
      cmp_n++; if (vld[1] !== 1'b1) begin fail_n++; $display("FAIL clr%0d_first_valid: got %b want 1", r, vld[1]); end
      cmp_n++; if (dout[1] !== 16'h60) begin fail_n++; $display("FAIL clr%0d_first_data: got %h want 0060", r, dout[1]); end
      cmp_n++; if (olast[1] !== 1'b1) begin fail_n++; $display("FAIL clr%0d_first_last: got %b want 1", r, olast[1]); end
      clk_step();
      ordy[1] = 1'b0;
    end
  endtask

  task automatic test_random();
    clear();
    for (int c = 0; c < 600; c++) begin
      for (int u = 0; u < 2; u++) begin
        vin[u]    = ($urandom_range(0, 3) != 0);
        din[u]    = 16'($urandom);
        lin[u]    = ($urandom_range(0, 3) == 0);
        ordy[u]   = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        en_v[u]   = ($urandom_range(0, 15) != 0);
        srst_v[u] = ($urandom_range(0, 79) == 0);
      end
      eval();
      for (int u = 0; u < 2; u++) begin
        cmp_n++; if (rdy[u] !== e_rdy[u]) begin fail_n++; $display("FAIL rnd_ready[%0d] c%0d: got %b want %b", u, c, rdy[u], e_rdy[u]); end
        cmp_n++; if (vld[u] !== e_vld[u]) begin fail_n++; $display("FAIL rnd_valid[%0d] c%0d: got %b want %b", u, c, vld[u], e_vld[u]); end
        cmp_n++; if (lvl[u] !== e_lvl[u]) begin fail_n++; $display("FAIL rnd_level[%0d] c%0d: got %0d want %0d", u, c, lvl[u], e_lvl[u]); end
        cmp_n++; if (pkt[u] !== e_pkt[u]) begin fail_n++; $display("FAIL rnd_pkt[%0d] c%0d: got %0d want %0d", u, c, pkt[u], e_pkt[u]); end
        cmp_n++; if (af[u] !== e_af[u]) begin fail_n++; $display("FAIL rnd_afull[%0d] c%0d: got %b want %b", u, c, af[u], e_af[u]); end
        cmp_n++; if (ae[u] !== e_ae[u]) begin fail_n++; $display("FAIL rnd_aempty[%0d] c%0d: got %b want %b", u, c, ae[u], e_ae[u]); end
        if (e_vld[u]) begin
          cmp_n++; if ({dout[u], olast[u]} !== e_head[u]) begin fail_n++; $display("FAIL rnd_head[%0d] c%0d: got %h want %h", u, c, {dout[u], olast[u]}, e_head[u]); end
        end
      end
      clk_step();
    end
    en_v = 2'b11; srst_v = 2'b00; vin = 2'b00; ordy = 2'b00;
  endtask

  initial begin
    nrst_v = 2'b11; srst_v = 2'b00; en_v = 2'b11;
    vin = 2'b00; lin = 2'b00; ordy = 2'b00; din = '0;
    @(negedge clk);
    test_reset();
    test_stream_fill();
    test_back_to_back();
    test_pkt_small();
    test_pkt_oversize();
    test_enable();
    test_local_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
